// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   - arb_state_e : request/accept/response FSM encoding
//   - arb_owner_e : which requester owns the in-flight transaction
//   - WinIfu/WinLsu : bit positions in the one-hot winner vector
//   - TimeoutRdata : data returned when a response times out
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnIfu  = 2'd1,
        OwnLsu  = 2'd2
    } arb_owner_e;

    localparam int unsigned WinIfu     = 0;
    localparam int unsigned WinLsu     = 1;
    localparam int unsigned StarveCntW = 4;

    localparam logic [31:0] TimeoutRdata = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select for the memory arbiter: LSU has fixed priority unless the IFU
// has been passed over STARVE_LIMIT consecutive times while waiting.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   ifu_req_i       IFU request pending
//   lsu_req_i       LSU request pending
//   grant_en_i      arbiter is idle and may grant this cycle
//   win_o           one-hot winner (bit WinIfu / WinLsu), combinational
module mem_arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ifu_req_i,
    input  logic       lsu_req_i,
    input  logic       grant_en_i,
    output logic [1:0] win_o
);

    localparam logic [StarveCntW-1:0] Limit = StarveCntW'(STARVE_LIMIT);

    logic [StarveCntW-1:0] starve_cnt_q, starve_cnt_d;
    logic                  starved;

    always_comb begin
        starved      = ifu_req_i && (starve_cnt_q == Limit);
        win_o        = '0;
        win_o[WinLsu] = lsu_req_i && !starved;
        win_o[WinIfu] = ifu_req_i && !win_o[WinLsu];

        starve_cnt_d = starve_cnt_q;
        if (grant_en_i) begin
            if (win_o[WinIfu]) begin
                starve_cnt_d = '0;
            end else if (win_o[WinLsu] && ifu_req_i && (starve_cnt_q != Limit)) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data-memory port between the IFU (read-only) and the LSU
// (read/write with byte mask). One transaction in flight at a time; requests
// are captured at grant and sequenced IDLE -> REQ -> RESP toward memory.
// Optional build macro MEM_ARBITER_TIMEOUT_EN adds a response timeout that
// completes with TimeoutRdata and pulses err_o; otherwise RESP waits forever.
// Ports:
//   clk_i, rst_ni                         clock, asynchronous active-low reset
//   ifu_req_i/addr_i, ifu_gnt_o           IFU request, 1-cycle grant pulse
//   ifu_rvalid_o, ifu_rdata_o             IFU response pulse and held data
//   lsu_req_i/wen_i/addr_i/wdata_i/wmask_i LSU request
//   lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o  LSU grant, response pulse, held data
//   mem_req_o/wen_o/addr_o/wdata_o/wmask_o memory request, stable until ready
//   mem_ready_i, mem_rvalid_i, mem_rdata_i memory accept and response
//   err_o                                 timeout pulse, aligned with rvalid
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ifu_req_i,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_gnt_o,
    output logic        ifu_rvalid_o,
    output logic [31:0] ifu_rdata_o,
    input  logic        lsu_req_i,
    input  logic        lsu_wen_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [3:0]  lsu_wmask_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        mem_req_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic        mem_ready_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);

    arb_state_e  state_q, state_d;
    arb_owner_e  owner_q, owner_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        ifu_rvalid_q, ifu_rvalid_d;
    logic        lsu_rvalid_q, lsu_rvalid_d;
    logic [31:0] ifu_rdata_q, ifu_rdata_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;
    logic        err_q, err_d;

    logic [1:0]  win;
    logic        idle;
    logic        tmo_hit;
    logic        resp_fire;
    logic [31:0] resp_data;

    assign idle = (state_q == StIdle);

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ifu_req_i  (ifu_req_i),
        .lsu_req_i  (lsu_req_i),
        .grant_en_i (idle),
        .win_o      (win)
    );

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    // Counts RESP cycles; sits at zero elsewhere, so it is clear on entry.
    assign tmo_cnt_d = (state_q == StResp) ? tmo_cnt_q + 8'd1 : 8'd0;
    assign tmo_hit   = (state_q == StResp) && (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        ifu_rdata_d  = ifu_rdata_q;
        lsu_rdata_d  = lsu_rdata_q;
        ifu_rvalid_d = 1'b0;
        lsu_rvalid_d = 1'b0;
        err_d        = 1'b0;
        resp_fire    = 1'b0;
        resp_data    = mem_rdata_i;

        unique case (state_q)
            StIdle: begin
                if (win[WinLsu]) begin
                    owner_d = OwnLsu;
                    wen_d   = lsu_wen_i;
                    addr_d  = lsu_addr_i;
                    wdata_d = lsu_wdata_i;
                    wmask_d = lsu_wmask_i;
                    state_d = StReq;
                end else if (win[WinIfu]) begin
                    owner_d = OwnIfu;
                    wen_d   = 1'b0;
                    addr_d  = ifu_addr_i;
                    wdata_d = 32'd0;
                    wmask_d = 4'd0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (mem_ready_i) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (mem_rvalid_i) begin
                    resp_fire = 1'b1;
                end else if (tmo_hit) begin
                    resp_fire = 1'b1;
                    resp_data = TimeoutRdata;
                    err_d     = 1'b1;
                end
                if (resp_fire) begin
                    state_d = StIdle;
                    // Write acks also load lsu_rdata; the LSU ignores it.
                    if (owner_q == OwnIfu) begin
                        ifu_rvalid_d = 1'b1;
                        ifu_rdata_d  = resp_data;
                    end else begin
                        lsu_rvalid_d = 1'b1;
                        lsu_rdata_d  = resp_data;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            owner_q      <= OwnNone;
            wen_q        <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wmask_q      <= 4'd0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            ifu_rdata_q  <= 32'd0;
            lsu_rdata_q  <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            ifu_rvalid_q <= ifu_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            ifu_rdata_q  <= ifu_rdata_d;
            lsu_rdata_q  <= lsu_rdata_d;
            err_q        <= err_d;
        end
    end

    assign ifu_gnt_o    = idle && win[WinIfu];
    assign lsu_gnt_o    = idle && win[WinLsu];
    assign ifu_rvalid_o = ifu_rvalid_q;
    assign ifu_rdata_o  = ifu_rdata_q;
    assign lsu_rvalid_o = lsu_rvalid_q;
    assign lsu_rdata_o  = lsu_rdata_q;
    assign err_o        = err_q;

    assign mem_req_o   = (state_q == StReq);
    assign mem_wen_o   = wen_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wmask_o = wmask_q;

endmodule
